phase_meter: RTL

PHASE_METER -- requirements
Module: phase_meter

---
 rtl/phase_meter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/phase_meter.sv
// Phase meter: measures the delay from a reference rising edge to the next
// rising edge on a measured channel, plus the reference period, in clk cycles.
module phase_meter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sig,
  input  logic          sig1,
  input  logic          hold,
  output logic [CW-1:0] delta,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REF,
    WAIT_CH,
    WAIT_END,
    REPORT
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state;
  logic          sig_q;
  logic          sig1_q;
  logic          ch_pend;
  logic [CW-1:0] cnt;
  logic [CW-1:0] delta_r;
  logic [CW-1:0] cnt_inc;
  logic          ref_rise;
  logic          ch_rise;
  logic          timeout;

  assign ref_rise = sig & ~sig_q;
  assign ch_rise  = sig1 & ~sig1_q;
  assign cnt_inc  = cnt + CNT_ONE;
  // Abort instead of letting cnt ever hold all-ones, so it can never wrap.
  assign timeout  = (cnt_inc == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sig_q   <= 1'b1;
      sig1_q  <= 1'b1;
      ch_pend <= 1'b0;
      cnt     <= '0;
      delta_r <= '0;
      delta   <= '0;
      period  <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      sig_q  <= sig;
      sig1_q <= sig1;
      valid  <= 1'b0;
      err    <= 1'b0;
      if (hold) begin
        state   <= WAIT_REF;
        cnt     <= '0;
        ch_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_REF;

          WAIT_REF: begin
            if (ref_rise) begin
              cnt <= '0;
              if (ch_rise) begin
                delta_r <= '0;
                state   <= WAIT_END;
              end else begin
                state <= WAIT_CH;
              end
            end
          end

          WAIT_CH: begin
            if (ref_rise) begin
              err <= 1'b1;
              cnt <= '0;
            end else if (timeout) begin
              err   <= 1'b1;
              cnt   <= '0;
              state <= WAIT_REF;
            end else begin
              cnt <= cnt_inc;
              if (ch_rise) begin
                delta_r <= cnt_inc;
                state   <= WAIT_END;
              end
            end
          end

          WAIT_END: begin
            if (ref_rise) begin
              // Outputs load on entry to REPORT so they are stable while valid is high.
              valid  <= 1'b1;
              delta  <= delta_r;
              period <= cnt_inc;
              cnt    <= '0;
              state  <= REPORT;
              if (ch_rise) begin
                delta_r <= '0;
                ch_pend <= 1'b1;
              end
            end else if (timeout) begin
              err   <= 1'b1;
              cnt   <= '0;
              state <= WAIT_REF;
            end else begin
              cnt <= cnt_inc;
            end
          end

          REPORT: begin
            // The closing edge is the next start; a coincident sig1 edge was captured as delta 0.
            cnt     <= cnt_inc;
            ch_pend <= 1'b0;
            if (ch_pend) begin
              state <= WAIT_END;
            end else if (ch_rise) begin
              delta_r <= cnt_inc;
              state   <= WAIT_END;
            end else begin
              state <= WAIT_CH;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
